// File: rtl/cbb_pulse_pacer.sv
// cbb_pulse_pacer
// Source-domain event pacer placed directly upstream of a pulse synchronizer.
// Bursty single-cycle event strobes are queued as a pending count and re-emitted
// as registered one-cycle pulses whose rising edges are exactly P_GAP_CYCLES
// apart while a backlog exists, so the downstream synchronizer never merges
// back-to-back pulses.
//
// Ports:
//   i_clk       source clock (only clock of the block)
//   i_rstn      asynchronous active-low reset
//   i_event     one event per cycle it is high
//   i_clr       synchronous flush: drops backlog, clears o_overflow
//   o_pulse     registered one-cycle pulse towards the synchronizer
//   o_pending   accepted, not-yet-fired event count
//   o_busy      FSM not idle or backlog non-empty
//   o_overflow  sticky: an event was dropped at saturation
module cbb_pulse_pacer #(
   parameter int P_GAP_CYCLES = 6,
   parameter int P_CNT_WIDTH  = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rstn,
   input  logic                   i_event,
   input  logic                   i_clr,
   output logic                   o_pulse,
   output logic [P_CNT_WIDTH-1:0] o_pending,
   output logic                   o_busy,
   output logic                   o_overflow
);

   localparam int GW = $clog2(P_GAP_CYCLES);
   localparam logic [GW-1:0]          GAP_LOAD = GW'(P_GAP_CYCLES - 1);
   localparam logic [GW-1:0]          GAP_ONE  = GW'(1);
   localparam logic [GW-1:0]          GAP_ZERO = GW'(0);
   localparam logic [P_CNT_WIDTH-1:0] CNT_MAX  = {P_CNT_WIDTH{1'b1}};
   localparam logic [P_CNT_WIDTH-1:0] CNT_ONE  = P_CNT_WIDTH'(1);
   localparam logic [P_CNT_WIDTH-1:0] CNT_ZERO = P_CNT_WIDTH'(0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FIRE = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t                  state_r;
   state_t                  state_nxt_s;
   logic [GW-1:0]           gap_cnt_r;
   logic [GW-1:0]           gap_nxt_s;
   logic [P_CNT_WIDTH-1:0]  pending_r;
   logic [P_CNT_WIDTH-1:0]  pending_nxt_s;
   logic                    overflow_r;
   logic                    overflow_nxt_s;
   logic                    pulse_r;
   logic                    busy_r;
   logic                    avail_s;
   logic                    take_s;
   logic                    acc_s;
   logic                    drop_s;
   logic                    pend_max_s;
   logic                    ev_ok_s;

   // Next-state, gap counter, pending-count and overflow computation
   always_comb begin
      state_nxt_s    = state_r;
      gap_nxt_s      = gap_cnt_r;
      pending_nxt_s  = pending_r;
      overflow_nxt_s = overflow_r;
      ev_ok_s        = i_event & ~i_clr;
      avail_s        = (pending_r != CNT_ZERO) | ev_ok_s;
      pend_max_s     = (pending_r == CNT_MAX);

      case (state_r)
         ST_IDLE: begin
            if (avail_s & ~i_clr) begin
               state_nxt_s = ST_FIRE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_FIRE: begin
            state_nxt_s = ST_GAP;
            gap_nxt_s   = GAP_LOAD;
         end
         ST_GAP: begin
            if (gap_cnt_r == GAP_ONE) begin
               gap_nxt_s = GAP_ZERO;
               if (avail_s & ~i_clr) begin
                  state_nxt_s = ST_FIRE;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end else begin
               gap_nxt_s = gap_cnt_r - GAP_ONE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            gap_nxt_s   = GAP_ZERO;
         end
      endcase

      // FIRE is never followed by FIRE, so entering FIRE is exactly "next is FIRE"
      take_s = (state_nxt_s == ST_FIRE);
      // An event is accepted unless the counter is full and nothing leaves this cycle
      acc_s  = ev_ok_s & ~(pend_max_s & ~take_s);
      drop_s = ev_ok_s & pend_max_s & ~take_s;

      if (i_clr) begin
         pending_nxt_s  = CNT_ZERO;
         overflow_nxt_s = 1'b0;
      end else begin
         // take with an empty counter always has acc set (avail needs the event)
         if (acc_s & ~take_s) begin
            pending_nxt_s = pending_r + CNT_ONE;
         end else if (take_s & ~acc_s) begin
            pending_nxt_s = pending_r - CNT_ONE;
         end else begin
            pending_nxt_s = pending_r;
         end
         overflow_nxt_s = overflow_r | drop_s;
      end
   end

   // State, counters and registered outputs
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_r    <= ST_IDLE;
         gap_cnt_r  <= GAP_ZERO;
         pending_r  <= CNT_ZERO;
         overflow_r <= 1'b0;
         pulse_r    <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         gap_cnt_r  <= gap_nxt_s;
         pending_r  <= pending_nxt_s;
         overflow_r <= overflow_nxt_s;
         pulse_r    <= (state_nxt_s == ST_FIRE);
         busy_r     <= (state_nxt_s != ST_IDLE) | (pending_nxt_s != CNT_ZERO);
      end
   end

   assign o_pulse    = pulse_r;
   assign o_pending  = pending_r;
   assign o_busy     = busy_r;
   assign o_overflow = overflow_r;

endmodule

// File: tb/tb_cbb_pulse_pacer.sv
// Testbench for cbb_pulse_pacer. Three instances cover the default build, a
// 2-bit pending counter and the minimum gap of 2; all share the stimulus and
// the active instance is selected per test.
module tb_cbb_pulse_pacer;

   logic       clk;
   logic       rstn;
   logic       ev;
   logic       clr;
   int         sel;

   logic       pulse_a, busy_a, ovf_a;
   logic [3:0] pend_a;
   logic       pulse_b, busy_b, ovf_b;
   logic [1:0] pend_b;
   logic       pulse_c, busy_c, ovf_c;
   logic [3:0] pend_c;

   logic       pulse_s, busy_s, ovf_s;
   logic [3:0] pend_s;

   int total;
   int bad;

   cbb_pulse_pacer u_a (
      .i_clk(clk), .i_rstn(rstn), .i_event(ev), .i_clr(clr),
      .o_pulse(pulse_a), .o_pending(pend_a), .o_busy(busy_a), .o_overflow(ovf_a)
   );

   cbb_pulse_pacer #(.P_GAP_CYCLES(6), .P_CNT_WIDTH(2)) u_b (
      .i_clk(clk), .i_rstn(rstn), .i_event(ev), .i_clr(clr),
      .o_pulse(pulse_b), .o_pending(pend_b), .o_busy(busy_b), .o_overflow(ovf_b)
   );

   cbb_pulse_pacer #(.P_GAP_CYCLES(2), .P_CNT_WIDTH(4)) u_c (
      .i_clk(clk), .i_rstn(rstn), .i_event(ev), .i_clr(clr),
      .o_pulse(pulse_c), .o_pending(pend_c), .o_busy(busy_c), .o_overflow(ovf_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Route the instance under test to the checker
   always_comb begin
      pulse_s = pulse_a;
      pend_s  = pend_a;
      busy_s  = busy_a;
      ovf_s   = ovf_a;
      case (sel)
         1: begin
            pulse_s = pulse_b;
            pend_s  = {2'b00, pend_b};
            busy_s  = busy_b;
            ovf_s   = ovf_b;
         end
         2: begin
            pulse_s = pulse_c;
            pend_s  = pend_c;
            busy_s  = busy_c;
            ovf_s   = ovf_c;
         end
         default: begin
            pulse_s = pulse_a;
            pend_s  = pend_a;
            busy_s  = busy_a;
            ovf_s   = ovf_a;
         end
      endcase
   end

   typedef struct {
      int          id;
      int          sel;
      int          ev_lo;
      int          ev_hi;
      int          clr_c;
      int          rst_c;
      int          ncyc;
      int          gap;
      logic [63:0] pmask;
      int          dropped;
      int          cleared;
   } test_t;

   typedef struct {
      int   id;
      int   cyc;
      int   pend;
      logic busy;
      logic ovf;
   } row_t;

   test_t tests[6];
   row_t  rows[$];

   task automatic chk(input int id, input int cyc, input string what, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL T%0d c%0d %s got=%0d want=%0d", id, cyc, what, got, want);
      end
   endtask

   task automatic run_test(input test_t t);
      int  fired;
      int  last_rise;
      logic prev;
      sel  = t.sel;
      rstn = 1'b0;
      ev   = 1'b0;
      clr  = 1'b0;
      repeat (3) @(negedge clk);
      rstn      = 1'b1;
      fired     = 0;
      last_rise = -1;
      prev      = 1'b0;
      for (int c = 0; c < t.ncyc; c++) begin
         if (c > 0) @(negedge clk);
         if (c == t.rst_c) begin
            rstn = 1'b0;
            #1;
         end
         chk(t.id, c, "pulse", int'(pulse_s), int'(t.pmask[c]));
         if (pulse_s && !prev) begin
            fired++;
            if (last_rise >= 0) chk(t.id, c, "edge_gap_ok", int'((c - last_rise) >= t.gap), 1);
            last_rise = c;
         end
         prev = pulse_s;
         foreach (rows[i]) begin
            if (rows[i].id == t.id && rows[i].cyc == c) begin
               chk(t.id, c, "pending",  int'(pend_s), rows[i].pend);
               chk(t.id, c, "busy",     int'(busy_s), int'(rows[i].busy));
               chk(t.id, c, "overflow", int'(ovf_s),  int'(rows[i].ovf));
            end
         end
         ev  = rstn && (c >= t.ev_lo) && (c <= t.ev_hi);
         clr = (c == t.clr_c);
      end
      chk(t.id, t.ncyc, "conservation", fired + t.dropped + t.cleared, t.ev_hi - t.ev_lo + 1);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      sel   = 0;
      rstn  = 1'b0;
      ev    = 1'b0;
      clr   = 1'b0;

      //            id sel lo  hi  clr  rst ncyc gap mask                      drop clrd
      tests[0] = '{1, 0, 10, 10, -1, -1, 30, 6, 64'h0000_0000_0000_0800, 0, 0};
      tests[1] = '{2, 0, 10, 12, -1, -1, 34, 6, 64'h0000_0000_0082_0800, 0, 0};
      tests[2] = '{3, 1, 10, 17, 45, -1, 50, 6, 64'h0000_0008_2082_0800, 3, 0};
      tests[3] = '{4, 0, 10, 14, 20, -1, 30, 6, 64'h0000_0000_0002_0800, 0, 3};
      tests[4] = '{5, 2, 10, 13, -1, -1, 24, 2, 64'h0000_0000_0002_A800, 0, 0};
      tests[5] = '{6, 0, 10, 12, -1, 19, 30, 6, 64'h0000_0000_0002_0800, 0, 1};

      // single event
      rows.push_back('{1,  0, 0, 1'b0, 1'b0});
      rows.push_back('{1, 10, 0, 1'b0, 1'b0});
      rows.push_back('{1, 11, 0, 1'b1, 1'b0});
      rows.push_back('{1, 16, 0, 1'b1, 1'b0});
      rows.push_back('{1, 17, 0, 1'b0, 1'b0});
      // burst of three
      rows.push_back('{2, 12, 1, 1'b1, 1'b0});
      rows.push_back('{2, 13, 2, 1'b1, 1'b0});
      rows.push_back('{2, 16, 2, 1'b1, 1'b0});
      rows.push_back('{2, 17, 1, 1'b1, 1'b0});
      rows.push_back('{2, 22, 1, 1'b1, 1'b0});
      rows.push_back('{2, 23, 0, 1'b1, 1'b0});
      rows.push_back('{2, 28, 0, 1'b1, 1'b0});
      rows.push_back('{2, 29, 0, 1'b0, 1'b0});
      // saturation with a 2-bit counter, then flush clears the sticky flag
      rows.push_back('{3, 14, 3, 1'b1, 1'b0});
      rows.push_back('{3, 15, 3, 1'b1, 1'b1});
      rows.push_back('{3, 18, 3, 1'b1, 1'b1});
      rows.push_back('{3, 23, 2, 1'b1, 1'b1});
      rows.push_back('{3, 35, 0, 1'b1, 1'b1});
      rows.push_back('{3, 41, 0, 1'b0, 1'b1});
      rows.push_back('{3, 46, 0, 1'b0, 1'b0});
      // flush mid-gap
      rows.push_back('{4, 15, 4, 1'b1, 1'b0});
      rows.push_back('{4, 17, 3, 1'b1, 1'b0});
      rows.push_back('{4, 20, 3, 1'b1, 1'b0});
      rows.push_back('{4, 21, 0, 1'b1, 1'b0});
      rows.push_back('{4, 22, 0, 1'b1, 1'b0});
      rows.push_back('{4, 23, 0, 1'b0, 1'b0});
      // minimum gap
      rows.push_back('{5, 12, 1, 1'b1, 1'b0});
      rows.push_back('{5, 14, 2, 1'b1, 1'b0});
      rows.push_back('{5, 16, 1, 1'b1, 1'b0});
      rows.push_back('{5, 17, 0, 1'b1, 1'b0});
      rows.push_back('{5, 18, 0, 1'b1, 1'b0});
      rows.push_back('{5, 19, 0, 1'b0, 1'b0});
      // asynchronous reset mid-operation
      rows.push_back('{6, 18, 1, 1'b1, 1'b0});
      rows.push_back('{6, 19, 0, 1'b0, 1'b0});
      rows.push_back('{6, 25, 0, 1'b0, 1'b0});

      for (int k = 0; k < 6; k++) begin
         run_test(tests[k]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
